// File: rtl/cwb_pkg.sv
// Shared types and helpers for the column window buffer.
package cwb_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StPad,
    StFlush,
    StDone
  } cwb_state_e;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  // Channel 0 occupies the most significant lane of tdata.
  function automatic int unsigned lane_lsb(input int unsigned tdata_w,
                                           input int unsigned data_w,
                                           input int unsigned ch);
    return tdata_w - (ch + 1) * data_w;
  endfunction

endpackage

// File: rtl/cwb_channel_array.sv
// One channel's HEIGHT x BLOCK_SIZE shift array; row 0 is presented as top_row.
module cwb_channel_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BLOCK_SIZE = 3,
  parameter int unsigned HEIGHT     = 480
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             shift_col,
  input  logic                             shift_pad,
  input  logic                             zero_px,
  input  logic [DATA_WIDTH-1:0]            pixel,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] ret_row,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] top_row
);

  localparam int unsigned RowW = BLOCK_SIZE * DATA_WIDTH;

  logic [RowW-1:0] rows_q [HEIGHT];
  logic [RowW-1:0] bottom_d;

  // Column advance takes the returned row one column left; pad keeps it aligned.
  always_comb begin
    bottom_d = '0;
    if (shift_col) begin
      bottom_d[RowW-DATA_WIDTH-1:0]       = ret_row[RowW-1:DATA_WIDTH];
      bottom_d[RowW-1 -: DATA_WIDTH]      = zero_px ? '0 : pixel;
    end else begin
      bottom_d[RowW-DATA_WIDTH-1:0]       = ret_row[RowW-DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int r = 0; r < int'(HEIGHT); r++) rows_q[r] <= '0;
    end else if (shift_col || shift_pad) begin
      for (int r = 0; r < int'(HEIGHT) - 1; r++) rows_q[r] <= rows_q[r+1];
      rows_q[HEIGHT-1] <= bottom_d;
    end
  end

  assign top_row = rows_q[0];

endmodule

// File: rtl/column_window_buffer.sv
// AXI-Stream column-major input buffer feeding a sliding-window block, with end-of-frame flush.
// Optional tlast checking is enabled by defining COLUMN_WINDOW_BUFFER_TLAST_CHECK_EN.
module column_window_buffer
  import cwb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned NUM_CHANNELS       = 3,
  parameter int unsigned BLOCK_SIZE         = 3,
  parameter int unsigned HEIGHT             = 480,
  parameter int unsigned PAD_CYCLES         = BLOCK_SIZE - 1,
  parameter int unsigned IMAGE_WIDTH        = 640,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic                                         s_axis_tvalid,
  output logic                                         s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]              s_axis_tstrb,
  input  logic                                         s_axis_tlast,
  input  logic [NUM_CHANNELS*BLOCK_SIZE*DATA_WIDTH-1:0] proc_in,
  output logic [NUM_CHANNELS*BLOCK_SIZE*DATA_WIDTH-1:0] proc_out,
  input  logic                                         output_has_back_pressure,
  output logic                                         data_flowing,
  output logic                                         is_full_columns_first_input,
  output logic                                         flushing,
  output logic                                         frame_done,
  output logic                                         err_tlast
);

  localparam int unsigned ChRowW = BLOCK_SIZE * DATA_WIDTH;
  localparam int unsigned RcW    = cnt_w(HEIGHT);
  localparam int unsigned PcW    = cnt_w(PAD_CYCLES);
  localparam int unsigned CcW    = cnt_w(IMAGE_WIDTH + BLOCK_SIZE - 1);
  localparam int unsigned DcW    = cnt_w(BLOCK_SIZE);

  localparam logic [RcW-1:0] RowLast  = RcW'(HEIGHT - 1);
  localparam logic [PcW-1:0] PadLast  = PcW'(PAD_CYCLES - 1);
  localparam logic [CcW-1:0] ColEnd   = CcW'(IMAGE_WIDTH + BLOCK_SIZE - 1);
  localparam logic [CcW-1:0] ColFlush = CcW'(IMAGE_WIDTH);
  localparam logic [DcW-1:0] DoneSat  = DcW'(BLOCK_SIZE);
  localparam logic [DcW-1:0] DoneFull = DcW'(BLOCK_SIZE - 1);

  cwb_state_e     state_q, state_d;
  logic [RcW-1:0] row_cnt_q, row_cnt_d;
  logic [PcW-1:0] pad_cnt_q, pad_cnt_d;
  logic [CcW-1:0] col_cnt_q, col_cnt_d, col_inc;
  logic [DcW-1:0] cols_done_q, cols_done_d;

  logic run;
  logic accept;
  logic shift_col;
  logic shift_pad;
  logic zero_px;
  logic [NUM_CHANNELS*ChRowW-1:0] top_rows;

  assign run       = aresetn && !output_has_back_pressure;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign shift_col = accept || (state_q == StFlush && run);
  assign shift_pad = (state_q == StPad) && run;
  assign zero_px   = (state_q == StFlush);
  assign col_inc   = col_cnt_q + 1'b1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StLoad;
      row_cnt_q   <= '0;
      pad_cnt_q   <= '0;
      col_cnt_q   <= '0;
      cols_done_q <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      col_cnt_q   <= col_cnt_d;
      cols_done_q <= cols_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    col_cnt_d   = col_cnt_q;
    cols_done_d = cols_done_q;
    unique case (state_q)
      StLoad, StFlush: begin
        if (shift_col) begin
          if (row_cnt_q == RowLast) begin
            row_cnt_d = '0;
            state_d   = StPad;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      StPad: begin
        if (run) begin
          if (pad_cnt_q == PadLast) begin
            pad_cnt_d   = '0;
            cols_done_d = (cols_done_q == DoneSat) ? cols_done_q : cols_done_q + 1'b1;
            col_cnt_d   = col_inc;
            if (col_inc >= ColEnd) begin
              state_d = StDone;
            end else if (col_inc >= ColFlush) begin
              state_d = StFlush;
            end else begin
              state_d = StLoad;
            end
          end else begin
            pad_cnt_d = pad_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        col_cnt_d   = '0;
        cols_done_d = '0;
        state_d     = StLoad;
      end
    endcase
  end

  // The flush phase covers the pad cycles of the zero columns as well.
  always_comb begin
    s_axis_tready               = 1'b0;
    data_flowing                = 1'b0;
    is_full_columns_first_input = 1'b0;
    flushing                    = 1'b0;
    frame_done                  = 1'b0;
    if (aresetn) begin
      s_axis_tready = (state_q == StLoad) && !output_has_back_pressure;
      data_flowing  = (s_axis_tready && s_axis_tvalid) ||
                      ((state_q == StPad || state_q == StFlush) && !output_has_back_pressure);
      is_full_columns_first_input = (state_q == StPad) && (pad_cnt_q == '0) &&
                                    (cols_done_q >= DoneFull);
      flushing   = (state_q == StFlush) || (state_q == StPad && col_cnt_q >= ColFlush);
      frame_done = (state_q == StDone);
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    cwb_channel_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .BLOCK_SIZE (BLOCK_SIZE),
      .HEIGHT     (HEIGHT)
    ) u_array (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .shift_col (shift_col),
      .shift_pad (shift_pad),
      .zero_px   (zero_px),
      .pixel     (s_axis_tdata[lane_lsb(C_AXIS_TDATA_WIDTH, DATA_WIDTH, c) +: DATA_WIDTH]),
      .ret_row   (proc_in[c*ChRowW +: ChRowW]),
      .top_row   (top_rows[c*ChRowW +: ChRowW])
    );
  end

  assign proc_out = aresetn ? top_rows : '0;

  logic unused_inputs;

`ifdef COLUMN_WINDOW_BUFFER_TLAST_CHECK_EN
  logic err_tlast_q;

  // row_cnt stays authoritative; tlast only raises a sticky flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_tlast_q <= 1'b0;
    end else if (accept && (s_axis_tlast != (row_cnt_q == RowLast))) begin
      err_tlast_q <= 1'b1;
    end
  end

  assign err_tlast     = aresetn && err_tlast_q;
  assign unused_inputs = ^{s_axis_tstrb, s_axis_tdata};
`else
  assign err_tlast     = 1'b0;
  assign unused_inputs = ^{s_axis_tstrb, s_axis_tdata, s_axis_tlast};
`endif

endmodule

// File: tb/tb_column_window_buffer.sv
// Directed self-checking bench for column_window_buffer with a 4-row, 4-column, 3-wide config.
module tb_column_window_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 3;
  localparam int unsigned BS = 3;
  localparam int unsigned H  = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned TW = 32;
  localparam int unsigned LW = NC * BS * DW;
`ifdef COLUMN_WINDOW_BUFFER_TLAST_CHECK_EN
  localparam bit TlastChk = 1'b1;
`else
  localparam bit TlastChk = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          tvalid;
  logic          tready;
  logic [TW-1:0] tdata;
  logic [TW/8-1:0] tstrb;
  logic          tlast;
  logic [LW-1:0] proc_in;
  logic [LW-1:0] proc_out;
  logic          bp;
  logic          df;
  logic          full;
  logic          flushing;
  logic          frame_done;
  logic          err_tlast;

  int checks   = 0;
  int failures = 0;
  int beat     = 0;
  bit inject   = 1'b0;

  always #5 aclk = ~aclk;

  column_window_buffer #(
    .DATA_WIDTH         (DW),
    .NUM_CHANNELS       (NC),
    .BLOCK_SIZE         (BS),
    .HEIGHT             (H),
    .PAD_CYCLES         (BS - 1),
    .IMAGE_WIDTH        (IW),
    .C_AXIS_TDATA_WIDTH (TW)
  ) dut (
    .aclk                        (aclk),
    .aresetn                     (aresetn),
    .s_axis_tvalid               (tvalid),
    .s_axis_tready               (tready),
    .s_axis_tdata                (tdata),
    .s_axis_tstrb                (tstrb),
    .s_axis_tlast                (tlast),
    .proc_in                     (proc_in),
    .proc_out                    (proc_out),
    .output_has_back_pressure    (bp),
    .data_flowing                (df),
    .is_full_columns_first_input (full),
    .flushing                    (flushing),
    .frame_done                  (frame_done),
    .err_tlast                   (err_tlast)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row pushed into the bottom of the array: 0 = column advance, 1 = pad, 2 = flush.
  function automatic logic [LW-1:0] exp_row(input int kind, input int b);
    logic [LW-1:0] r;
    logic [7:0]    base;
    r = '0;
    for (int c = 0; c < int'(NC); c++) begin
      base = 8'hA0 + 8'(c * 16);
      case (kind)
        0: begin
          r[(c*BS)*DW +: DW]   = base + 8'd1;
          r[(c*BS+1)*DW +: DW] = base + 8'd2;
          r[(c*BS+2)*DW +: DW] = 8'(b + 1 + 64 * c);
        end
        1: begin
          r[(c*BS)*DW +: DW]   = base;
          r[(c*BS+1)*DW +: DW] = base + 8'd1;
        end
        default: begin
          r[(c*BS)*DW +: DW]   = base + 8'd1;
          r[(c*BS+1)*DW +: DW] = base + 8'd2;
        end
      endcase
    end
    return r;
  endfunction

  task automatic drive_beat();
    tdata = {8'(beat + 1), 8'(beat + 8'h41), 8'(beat + 8'h81), 8'h00};
    tlast = ((beat % 4) == 3) || (inject && beat == 6);
  endtask

  task automatic step();
    logic acc;
    @(negedge aclk);
    acc = tvalid && tready;
    @(posedge aclk);
    #1;
    if (acc) begin
      beat++;
      drive_beat();
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bp      = 1'b0;
    beat    = 0;
    drive_beat();
    step();
    step();
    aresetn = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_df, n_fl, n_fd, fd_at;
    logic [36:0] full_m, full_exp;

    aresetn = 1'b0;
    bp      = 1'b0;
    tvalid  = 1'b1;
    tstrb   = '1;
    inject  = 1'b1;
    beat    = 0;
    drive_beat();
    for (int c = 0; c < int'(NC); c++)
      for (int j = 0; j < int'(BS); j++)
        proc_in[(c*BS+j)*DW +: DW] = 8'hA0 + 8'(c * 16 + j);

    @(posedge aclk);
    #1;
    chk("rst_low_tready", tready, 0);
    step();
    chk("rst_proc_out", proc_out, '0);
    chk("rst_data_flowing", df, 0);
    chk("rst_status", {full, flushing, frame_done, err_tlast}, 0);
    aresetn = 1'b1;
    #1;
    chk("load_tready", tready, 1);

    // Full frame with no back pressure; tlast deliberately wrong on beat 6.
    n_df = 0; n_fl = 0; n_fd = 0; fd_at = -1;
    full_m = '0;
    full_exp = '0;
    full_exp[16] = 1'b1;
    full_exp[22] = 1'b1;
    full_exp[28] = 1'b1;
    full_exp[34] = 1'b1;
    for (int m = 0; m <= 36; m++) begin
      if (m == 4) chk("col0_top_beat0", proc_out, exp_row(0, 0));
      if (m == 4) chk("pad_tready", tready, 0);
      if (m == 6) chk("col1_tready", tready, 1);
      if (m == 8) chk("pad_row_top", proc_out, exp_row(1, 0));
      if (m == 8) chk("err_tlast_before", err_tlast, 0);
      if (m == 9) chk("err_tlast_set", err_tlast, TlastChk);
      if (m == 10) chk("col1_top_beat4", proc_out, exp_row(0, 4));
      if (m == 24) chk("flush_tready", tready, 0);
      if (m == 28) chk("flush_row_top", proc_out, exp_row(2, 0));
      if (m == 36) chk("err_tlast_sticky", err_tlast, TlastChk);
      if (df) n_df++;
      if (flushing) n_fl++;
      if (frame_done) begin
        n_fd++;
        fd_at = m;
      end
      full_m[m] = full;
      step();
    end
    chk("frame_data_flowing_cycles", n_df, 36);
    chk("frame_flushing_cycles", n_fl, 12);
    chk("frame_done_count", n_fd, 1);
    chk("frame_done_cycle", fd_at, 36);
    chk("full_columns_pulses", full_m, full_exp);
    chk("after_done_tready", tready, 1);
    chk("after_done_pulse", frame_done, 0);

    // Back pressure mid-column and mid-pad.
    inject = 1'b0;
    do_reset();
    chk("reset_clears_err", err_tlast, 0);
    for (int m = 0; m < 8; m++) step();
    chk("bp1_pre_top", proc_out, exp_row(1, 0));
    bp = 1'b1;
    #1;
    chk("bp1_tready", tready, 0);
    chk("bp1_flowing", df, 0);
    for (int m = 0; m < 5; m++) begin
      step();
      chk("bp1_frozen_top", proc_out, exp_row(1, 0));
      chk("bp1_frozen_flow", df, 0);
    end
    bp = 1'b0;
    #1;
    chk("bp1_resume_tready", tready, 1);
    step();
    step();
    chk("bp1_resume_top", proc_out, exp_row(0, 4));
    chk("bp1_pad_entry", tready, 0);
    step();
    chk("bp2_pre_top", proc_out, exp_row(0, 5));
    bp = 1'b1;
    #1;
    chk("bp2_flowing", df, 0);
    for (int m = 0; m < 5; m++) begin
      step();
      chk("bp2_frozen_top", proc_out, exp_row(0, 5));
      chk("bp2_frozen_ctl", {df, tready}, 0);
    end
    bp = 1'b0;
    #1;
    chk("bp2_resume_flow", df, 1);
    step();
    chk("bp2_resume_top", proc_out, exp_row(0, 6));
    chk("bp2_resume_tready", tready, 1);

    // Reset pulse during flush abandons the frame.
    do_reset();
    for (int m = 0; m < 26; m++) step();
    chk("pre_abort_flushing", flushing, 1);
    aresetn = 1'b0;
    #1;
    chk("abort_rst_outputs", {tready, flushing, frame_done}, 0);
    chk("abort_rst_proc_out", proc_out, '0);
    step();
    aresetn = 1'b1;
    beat    = 0;
    drive_beat();
    #1;
    chk("abort_load_tready", tready, 1);
    chk("abort_proc_out", proc_out, '0);
    chk("abort_status", {flushing, frame_done}, 0);
    bp = 1'b1;
    #1;
    chk("abort_tready_bp", tready, 0);
    bp = 1'b0;
    #1;
    n_fd = 0;
    for (int m = 0; m < 36; m++) begin
      if (frame_done) n_fd++;
      step();
    end
    chk("abort_no_frame_done", n_fd, 0);
    chk("new_frame_done", frame_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
